// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction bus, redirect input, FIFO write port and status.
// inst_req/inst_addr_ok: a request is accepted in the cycle both are high.
// inst_data_ok returns the accepted request's instruction pair, one request in flight.
interface inst_fetch_ctrl_if;
  logic        fifo_full;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata1;
  logic [31:0] inst_rdata2;
  logic        fifo_rst;
  logic        write_en1;
  logic        write_en2;
  logic [31:0] write_address1;
  logic [31:0] write_address2;
  logic [31:0] write_data1;
  logic [31:0] write_data2;
  logic        fetch_adel;

  modport master (
    input  fifo_full, redirect_en, redirect_pc,
    input  inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2,
    output inst_req, inst_addr, fifo_rst,
    output write_en1, write_en2, write_address1, write_address2,
    output write_data1, write_data2, fetch_adel
  );

  modport slave (
    output fifo_full, redirect_en, redirect_pc,
    output inst_addr_ok, inst_data_ok, inst_rdata1, inst_rdata2,
    input  inst_req, inst_addr, fifo_rst,
    input  write_en1, write_en2, write_address1, write_address2,
    input  write_data1, write_data2, fetch_adel
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues 2-wide instruction requests one at a
// time, writes returned pairs into the instruction FIFO and handles redirects.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_ctrl_if.master  bus,
  output logic [1:0]         fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_req_q, pc_req_d;
  logic        fetch_adel_q;
  logic        issue;
  logic        deliver;

  assign issue   = (state_q == S_REQ) & ~bus.fifo_full & ~fetch_adel_q & ~bus.redirect_en;
  assign deliver = (state_q == S_WAIT) & bus.inst_data_ok & ~bus.redirect_en;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_req_d = pc_req_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (bus.redirect_en) begin
          if (bus.inst_addr_ok) state_d = S_DISCARD;
        end else if (issue && bus.inst_addr_ok) begin
          state_d  = S_WAIT;
          pc_req_d = pc_q;
        end
      end
      S_WAIT: begin
        if (bus.inst_data_ok)     state_d = S_REQ;
        else if (bus.redirect_en) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (bus.inst_data_ok) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    // An odd-word fetch only reaches the end of its 8-byte block.
    if (deliver) pc_d = pc_req_q + (pc_req_q[2] ? 32'd4 : 32'd8);
    if (bus.redirect_en) pc_d = bus.redirect_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pc_req_q     <= RESET_PC;
      fetch_adel_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_req_q     <= pc_req_d;
      fetch_adel_q <= |pc_d[1:0];
    end
  end

  assign bus.inst_req       = issue & ~rst;
  assign bus.inst_addr      = pc_q;
  assign bus.fifo_rst       = rst | bus.redirect_en;
  assign bus.write_en1      = deliver & ~rst;
  assign bus.write_en2      = deliver & ~rst & ~pc_req_q[2];
  assign bus.write_address1 = pc_req_q;
  assign bus.write_address2 = pc_req_q + 32'd4;
  assign bus.write_data1    = bus.inst_rdata1;
  assign bus.write_data2    = bus.inst_rdata2;
  assign bus.fetch_adel     = fetch_adel_q;
  assign fsm_state_o        = state_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: a bus/FIFO environment with a fetch-address model
// feeding an expected-write queue that an independent monitor drains.
module tb_inst_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fsm_state;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fsm_state_o (fsm_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // {en2, addr1, data1, addr2, data2}
  logic [128:0] exp_q[$];

  logic [31:0] model_pc;
  logic [31:0] req_addr;
  bit          outstanding;
  bit          cancelled;
  bit          first_cycle;
  int          countdown;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle_inputs();
    bus.fifo_full    = 1'b0;
    bus.redirect_en  = 1'b0;
    bus.redirect_pc  = 32'h0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata1  = 32'h0;
    bus.inst_rdata2  = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle_inputs();
    #1;
    chk("rst_inst_req", bus.inst_req, 0);
    chk("rst_write_en1", bus.write_en1, 0);
    chk("rst_write_en2", bus.write_en2, 0);
    chk("rst_fifo_rst", bus.fifo_rst, 1);
    @(negedge clk);
    #1;
    chk("rst_fetch_adel", bus.fetch_adel, 0);
    chk("rst_inst_addr", bus.inst_addr, RESET_PC);
    model_pc    = RESET_PC;
    outstanding = 0;
    cancelled   = 0;
    first_cycle = 1;
  endtask

  // One clock of environment behaviour plus the per-cycle output checks.
  task automatic cycle(input bit full, input bit redir, input logic [31:0] rpc,
                       input bit accept, input int delay, input bit stale = 0);
    bit data_now;
    bit exp_req;
    bit was_cancelled;
    @(negedge clk);
    rst             = 1'b0;
    bus.fifo_full   = full;
    bus.redirect_en = redir;
    bus.redirect_pc = rpc;
    bus.inst_addr_ok = 1'b0;
    data_now = outstanding && (countdown == 0);
    bus.inst_data_ok = data_now | stale;
    if (data_now) begin
      bus.inst_rdata1 = mem_word(req_addr);
      bus.inst_rdata2 = mem_word(req_addr + 32'd4);
    end else begin
      bus.inst_rdata1 = $urandom;
      bus.inst_rdata2 = $urandom;
    end
    #1;
    exp_req = !outstanding && !first_cycle && !full && (model_pc[1:0] == 2'b00) && !redir;
    chk("fifo_rst", bus.fifo_rst, redir);
    chk("fetch_adel", bus.fetch_adel, |model_pc[1:0]);
    chk("inst_req", bus.inst_req, exp_req);
    if (exp_req) chk("inst_addr", bus.inst_addr, model_pc);

    was_cancelled = cancelled;
    if (data_now && !redir && !was_cancelled)
      exp_q.push_back({~req_addr[2], req_addr, mem_word(req_addr),
                       req_addr + 32'd4, mem_word(req_addr + 32'd4)});
    bus.inst_addr_ok = accept && exp_req;

    if (data_now) begin
      outstanding = 0;
      cancelled   = 0;
      if (!redir && !was_cancelled)
        model_pc = req_addr + (req_addr[2] ? 32'd4 : 32'd8);
    end else if (outstanding) begin
      countdown--;
    end
    if (redir) begin
      model_pc = rpc;
      if (outstanding) cancelled = 1;
    end
    if (accept && exp_req) begin
      outstanding = 1;
      req_addr    = model_pc;
      countdown   = delay;
    end
    first_cycle = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 32'h0, 0, 0);
  endtask

  // Monitor: every FIFO write must match the oldest expected pair.
  initial begin
    logic [128:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (bus.write_en1 === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%h expected no write at %0t",
                   bus.write_address1, $time);
        end else begin
          e = exp_q.pop_front();
          chk("write_en2", bus.write_en2, e[128]);
          chk("write_address1", bus.write_address1, e[127:96]);
          chk("write_data1", bus.write_data1, e[95:64]);
          chk("write_address2", bus.write_address2, e[63:32]);
          chk("write_data2", bus.write_data2, e[31:0]);
        end
      end else begin
        chk("write_en2_alone", bus.write_en2, 0);
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    int          sel;
    rst = 1'b1;
    drive_idle_inputs();
    do_reset();

    // Reset fetch; a stale data_ok in the post-reset cycle must be ignored.
    cycle(0, 0, 32'h0, 1, 1, 1);
    cycle(0, 0, 32'h0, 1, 1);
    idle(3);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // Redirect to an odd word: single-slot write, then block-aligned fetch.
    cycle(0, 1, 32'h8000_0004, 0, 0);
    cycle(0, 0, 32'h0, 1, 0);
    idle(1);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // FIFO full holds off requests, release issues in the same cycle.
    repeat (5) cycle(1, 0, 32'h0, 1, 0);
    cycle(0, 0, 32'h0, 1, 2);
    idle(4);

    // Redirect while waiting: the late data is dropped.
    cycle(0, 0, 32'h0, 1, 3);
    cycle(0, 1, 32'h8000_1000, 0, 0);
    idle(4);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // Redirect coincident with data_ok.
    cycle(0, 0, 32'h0, 1, 0);
    cycle(0, 1, 32'h8000_2000, 0, 0);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // Misaligned redirect halts fetch until an aligned redirect.
    cycle(0, 1, 32'h8000_0002, 0, 0);
    repeat (10) cycle(0, 0, 32'h0, 1, 0);
    cycle(0, 1, 32'h8000_0000, 0, 0);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // PC wraps past the top of the address space.
    cycle(0, 1, 32'hFFFF_FFF8, 0, 0);
    cycle(0, 0, 32'h0, 1, 0);
    idle(1);
    cycle(0, 0, 32'h0, 1, 0);
    idle(2);

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        do_reset();
        cycle(0, 0, 32'h0, 1, 0, 1);
      end
      sel = $urandom_range(0, 15);
      if (sel == 0)      rpc = ($urandom & ~32'd3) | 32'($urandom_range(1, 3));
      else if (sel == 1) rpc = 32'hFFFF_FFF8;
      else if (sel == 2) rpc = 32'hFFFF_FFFC;
      else               rpc = $urandom & ~32'd3;
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, rpc,
            $urandom_range(0, 2) != 0, $urandom_range(0, 3));
    end

    idle(6);
    chk("expected_queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
